// File: rtl/down_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer_if
//  Description : Control/status bundle between a timer client and down_timer.
//  Revision    : 1.0  initial release
// ============================================================================
interface down_timer_if #(
    parameter int W = 23
);
    logic         ena;
    logic         start;
    logic [W-1:0] load;
    logic         reload;
    logic         pause;
    logic         stop;
    logic         busy;
    logic         expire;
    logic [W-1:0] count;

    modport master (
        output ena, start, load, reload, pause, stop,
        input  busy, expire, count
    );

    modport slave (
        input  ena, start, load, reload, pause, stop,
        output busy, expire, count
    );
endinterface
`default_nettype wire

// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer
//  Description : Programmable down-counting timer, one-shot or auto-reload,
//                decrementing once per qualified ena tick.
//  Revision    : 1.0  initial release
// ============================================================================
module down_timer #(
    parameter int W = 23
) (
    input  wire logic    clk,
    input  wire logic    rst_,
    down_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0] C_ZERO = {W{1'b0}};
    localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [W-1:0] r_count;
    logic [W-1:0] r_period;
    logic         r_mode;
    logic         r_expire;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= S_IDLE;
            r_count  <= C_ZERO;
            r_period <= C_ZERO;
            r_mode   <= 1'b0;
            r_expire <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            if (bus.stop) begin
                r_state <= S_IDLE;
                r_count <= C_ZERO;
            end else if (bus.start) begin
                if (bus.load != C_ZERO) begin
                    r_count  <= bus.load;
                    r_period <= bus.load;
                    r_mode   <= bus.reload;
                    r_state  <= bus.pause ? S_HOLD : S_RUN;
                end else begin
                    // A zero-length timeout expires immediately and never runs.
                    r_expire <= 1'b1;
                    r_count  <= C_ZERO;
                    r_state  <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (bus.pause) begin
                            r_state <= S_HOLD;
                        end else if (bus.ena) begin
                            if (r_count == C_ONE) begin
                                r_expire <= 1'b1;
                                if (r_mode) begin
                                    r_count <= r_period;
                                end else begin
                                    r_count <= C_ZERO;
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_count <= r_count - C_ONE;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!bus.pause) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.expire = r_expire;
    assign bus.count  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_timer
//  Description : Self-checking bench for down_timer (vector table + sequences).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_down_timer;
    localparam int W = 23;

    typedef struct {
        string        nm;
        logic         start;
        logic [W-1:0] load;
        logic         reload;
        logic         pause;
        logic         stop;
        logic         ena;
        logic [W-1:0] ecount;
        logic         ebusy;
        logic         eexp;
    } vec_t;

    typedef struct {
        string        nm;
        logic [W-1:0] count;
        logic         busy;
        logic         expire;
    } exp_t;

    logic clk;
    logic rst_;
    int   tests;
    int   fails;
    vec_t tbl[$];
    exp_t sb[$];

    down_timer_if #(.W(W)) bus ();

    down_timer #(.W(W)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input string nm, input logic st, input int ld,
                                input logic rl, input logic ps, input logic sp,
                                input logic en, input int ec, input logic eb,
                                input logic ee);
        vec_t v;
        v.nm = nm; v.start = st; v.load = W'(ld); v.reload = rl; v.pause = ps;
        v.stop = sp; v.ena = en; v.ecount = W'(ec); v.ebusy = eb; v.eexp = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input string what, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, what, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs,
    // then pop and compare once the edge has been taken.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.start  = v.start;
        bus.load   = v.load;
        bus.reload = v.reload;
        bus.pause  = v.pause;
        bus.stop   = v.stop;
        bus.ena    = v.ena;
        sb.push_back('{v.nm, v.ecount, v.ebusy, v.eexp});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.nm, "count",  int'(bus.count), int'(e.count));
        chk(e.nm, "busy",   int'(bus.busy),  int'(e.busy));
        chk(e.nm, "expire", int'(bus.expire), int'(e.expire));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.start = 1'b0; bus.load = '0; bus.reload = 1'b0;
        bus.pause = 1'b0; bus.stop = 1'b0; bus.ena = 1'b0;

        // One-shot, load=5, ena tied high
        tbl.push_back(mk("os_start", 1, 5, 0, 0, 0, 1, 5, 1, 0));
        tbl.push_back(mk("os_t1",    0, 0, 0, 0, 0, 1, 4, 1, 0));
        tbl.push_back(mk("os_t2",    0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk("os_t3",    0, 0, 0, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk("os_t4",    0, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk("os_term",  0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("os_after", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Zero load: single expire, never busy
        tbl.push_back(mk("z_start",  1, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("z_after",  0, 0, 1, 0, 0, 1, 0, 0, 0));
        // Retrigger with load=7 on the terminal tick suppresses the expire
        tbl.push_back(mk("rt_start", 1, 4, 0, 0, 0, 1, 4, 1, 0));
        tbl.push_back(mk("rt_t1",    0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk("rt_t2",    0, 0, 0, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk("rt_t3",    0, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk("rt_retrig",1, 7, 0, 0, 0, 1, 7, 1, 0));
        tbl.push_back(mk("rt_next",  0, 0, 0, 0, 0, 1, 6, 1, 0));
        // Stop wins over start in the same cycle
        tbl.push_back(mk("ss_both",  1, 9, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("ss_after", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Stop on the terminal tick of an auto-reload run
        tbl.push_back(mk("ts_start", 1, 2, 1, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk("ts_t1",    0, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk("ts_stop",  0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("ts_after", 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Start with pause held lands in HOLD; resume cycle does not tick
        tbl.push_back(mk("ph_start", 1, 3, 0, 1, 0, 1, 3, 1, 0));
        tbl.push_back(mk("ph_hold",  0, 0, 0, 1, 0, 1, 3, 1, 0));
        tbl.push_back(mk("ph_resume",0, 0, 0, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk("ph_tick",  0, 0, 0, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk("ph_stop",  0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Reset state, then 10 quiet cycles
        rst_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "count",  int'(bus.count),  0);
        chk("reset", "busy",   int'(bus.busy),   0);
        chk("reset", "expire", int'(bus.expire), 0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 10; i++)
            step(mk("quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i])
            step(tbl[i]);

        // Auto-reload, load=3, ena on every 2nd cycle: expire every 6 clocks
        step(mk("ar_start", 1, 3, 1, 0, 0, 0, 3, 1, 0));
        for (int i = 1; i <= 25; i++) begin
            int  k;
            logic en;
            en = (i % 2 == 0);
            k  = i / 2;
            step(mk("ar_run", 0, 0, 0, 0, 0, en, 3 - (k % 3), 1,
                    en && (k % 3 == 0)));
        end
        step(mk("ar_stop", 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Pause after 4 ticks for 20 cycles, resume, stop at count=3
        step(mk("ps_start", 1, 10, 0, 0, 0, 1, 10, 1, 0));
        for (int i = 1; i <= 4; i++)
            step(mk("ps_tick", 0, 0, 0, 0, 0, 1, 10 - i, 1, 0));
        for (int i = 0; i < 20; i++)
            step(mk("ps_paused", 0, 0, 0, 1, 0, 1, 6, 1, 0));
        step(mk("ps_resume", 0, 0, 0, 0, 0, 1, 6, 1, 0));
        for (int i = 1; i <= 3; i++)
            step(mk("ps_run", 0, 0, 0, 0, 0, 1, 6 - i, 1, 0));
        step(mk("ps_stop", 0, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step(mk("ps_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0));

        // Asynchronous reset mid-count, checked while clk is low
        step(mk("ar2_start", 1, 20, 1, 0, 0, 1, 20, 1, 0));
        step(mk("ar2_tick",  0, 0, 0, 0, 0, 1, 19, 1, 0));
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        chk("async_rst", "count",  int'(bus.count),  0);
        chk("async_rst", "busy",   int'(bus.busy),   0);
        chk("async_rst", "expire", int'(bus.expire), 0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        for (int i = 0; i < 3; i++)
            step(mk("post_rst", 0, 0, 0, 0, 0, 1, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
